// File: rtl/sized_fifo.sv
// sized_fifo: parametrised FWFT FIFO with occupancy count, almost flags and sticky error flags
module sized_fifo #(
    parameter int width = 8,
    parameter int depth = 4,
    parameter int af_thresh = depth - 1,
    parameter int ae_thresh = 1,
    localparam int cw = $clog2(depth + 1)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [width-1:0] D_IN,
    input  logic             ENQ,
    input  logic             DEQ,
    input  logic             CLR,
    output logic [width-1:0] D_OUT,
    output logic             FULL_N,
    output logic             EMPTY_N,
    output logic [cw-1:0]    COUNT,
    output logic             ALMOST_FULL,
    output logic             ALMOST_EMPTY,
    output logic             OVF,
    output logic             UDF
);
    localparam int pw = $clog2(depth);

    logic [width-1:0] mem [depth];
    logic [pw-1:0]    wr_ptr, rd_ptr;
    logic [cw-1:0]    count;
    logic             enq_ok, deq_ok;

    // flags come from registered count only, never from ENQ/DEQ
    always_comb begin
        FULL_N       = count != cw'(depth);
        EMPTY_N      = count != '0;
        COUNT        = count;
        ALMOST_FULL  = count >= cw'(af_thresh);
        ALMOST_EMPTY = count <= cw'(ae_thresh);
        D_OUT        = EMPTY_N ? mem[rd_ptr] : '0;
        enq_ok       = ENQ & FULL_N & ~CLR;
        deq_ok       = DEQ & EMPTY_N & ~CLR;
    end

    // storage is deliberately left out of reset
    always_ff @(posedge CLK) begin
        if (enq_ok) mem[wr_ptr] <= D_IN;
    end

    // pointers wrap explicitly so any depth works; count is tracked on its own
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            OVF    <= 1'b0;
            UDF    <= 1'b0;
        end else if (CLR) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            OVF    <= 1'b0;
            UDF    <= 1'b0;
        end else begin
            if (enq_ok) wr_ptr <= (wr_ptr == pw'(depth - 1)) ? '0 : wr_ptr + pw'(1);
            if (deq_ok) rd_ptr <= (rd_ptr == pw'(depth - 1)) ? '0 : rd_ptr + pw'(1);
            count <= (enq_ok && !deq_ok) ? count + cw'(1) :
                     (deq_ok && !enq_ok) ? count - cw'(1) : count;
            OVF   <= OVF | (ENQ & ~FULL_N);
            UDF   <= UDF | (DEQ & ~EMPTY_N);
        end
    end
endmodule
